// File: rtl/mem1_stage.sv
// mem1_stage: data-memory access stage (byte/half/word load/store) with a
// registered valid/ready output toward write-back; misaligned ops flagged.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   valid_i / ready_o            upstream handshake (ready_o = ~valid_o | ready_i)
//   opr0_i, opr1_i               operands (opr1_i is store data)
//   dm_addr_i, mem_wen_i         byte address, 1 = store
//   dm_dopc_i                    [1:0] size (00 none/01 b/10 h/11 w), [2] zero-extend
//   pe_out_i .. next_uni_opr_i   sideband, registered through unchanged
//   valid_o / ready_i            downstream handshake
//   result_o, opr1_o             load data or opr0, registered opr1
//   *_o sideband                 registered sideband copies
//   misalign_o, err_o            token misaligned, sticky misalignment flag
module mem1_stage #(
    parameter int DM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] opr0_i,
    input  logic [31:0] opr1_i,
    input  logic [13:0] dm_addr_i,
    input  logic        mem_wen_i,
    input  logic [2:0]  dm_dopc_i,
    input  logic        pe_out_i,
    input  logic [2:0]  pe_num_i,
    input  logic        f_mem_w_i,
    input  logic        next_lr_i,
    input  logic [15:0] next_node_i,
    input  logic [11:0] gen_i,
    input  logic        next_uni_opr_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic [31:0] opr1_o,
    output logic        pe_out_o,
    output logic [2:0]  pe_num_o,
    output logic        f_mem_w_o,
    output logic        next_lr_o,
    output logic [15:0] next_node_o,
    output logic [11:0] gen_o,
    output logic        next_uni_opr_o,
    output logic        misalign_o,
    output logic        err_o
);

    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]   mem_q [DM_WORDS];

    logic          valid_q;
    logic [31:0]   result_q;
    logic [31:0]   opr1_q;
    logic          pe_out_q;
    logic [2:0]    pe_num_q;
    logic          f_mem_w_q;
    logic          next_lr_q;
    logic [15:0]   next_node_q;
    logic [11:0]   gen_q;
    logic          next_uni_opr_q;
    logic          misalign_q;
    logic          err_q;

    logic          acc;
    logic [1:0]    size;
    logic          is_mem;
    logic          is_st;
    logic          is_ld;
    logic          mis;
    logic          wr_en;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ldata;
    logic [31:0]   result_d;
    logic          err_d;

    assign ready_o = ~valid_q | ready_i;
    assign acc     = valid_i & ready_o;

    assign size   = dm_dopc_i[1:0];
    assign is_mem = size != 2'b00;
    assign is_st  = is_mem & mem_wen_i;
    assign is_ld  = is_mem & ~mem_wen_i;
    assign mis    = ((size == 2'b10) & dm_addr_i[0]) |
                    ((size == 2'b11) & (dm_addr_i[1:0] != 2'b00));
    // Reset edge must never commit a pending store.
    assign wr_en  = acc & ~rst & is_st & ~mis;
    assign widx   = dm_addr_i[AW+1:2];

    always_comb begin
        be    = 4'b0000;
        wdata = opr1_i;
        unique case (size)
            2'b01: begin
                be    = 4'b0001 << dm_addr_i[1:0];
                wdata = {4{opr1_i[7:0]}};
            end
            2'b10: begin
                be    = dm_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata = {2{opr1_i[15:0]}};
            end
            2'b11:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[widx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rword = mem_q[widx];
    assign bsel  = rword[{dm_addr_i[1:0], 3'b000} +: 8];
    assign hsel  = dm_addr_i[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ldata = rword;
        unique case (size)
            2'b01: ldata = dm_dopc_i[2] ? {24'd0, bsel}
                                        : {{24{bsel[7]}}, bsel};
            2'b10: ldata = dm_dopc_i[2] ? {16'd0, hsel}
                                        : {{16{hsel[15]}}, hsel};
            default: ldata = rword;
        endcase
    end

    always_comb begin
        result_d = opr0_i;
        err_d    = err_q;
        if (is_mem & mis) begin
            result_d = 32'd0;
            err_d    = 1'b1;
        end else if (is_ld) begin
            result_d = ldata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= 1'b0;
            result_q       <= 32'd0;
            opr1_q         <= 32'd0;
            pe_out_q       <= 1'b0;
            pe_num_q       <= 3'd0;
            f_mem_w_q      <= 1'b0;
            next_lr_q      <= 1'b0;
            next_node_q    <= 16'd0;
            gen_q          <= 12'd0;
            next_uni_opr_q <= 1'b0;
            misalign_q     <= 1'b0;
            err_q          <= 1'b0;
        end else if (acc) begin
            valid_q        <= 1'b1;
            result_q       <= result_d;
            opr1_q         <= opr1_i;
            pe_out_q       <= pe_out_i;
            pe_num_q       <= pe_num_i;
            f_mem_w_q      <= f_mem_w_i;
            next_lr_q      <= next_lr_i;
            next_node_q    <= next_node_i;
            gen_q          <= gen_i;
            next_uni_opr_q <= next_uni_opr_i;
            misalign_q     <= is_mem & mis;
            err_q          <= err_d;
        end else if (ready_i) begin
            valid_q        <= 1'b0;
        end
    end

    assign valid_o        = valid_q;
    assign result_o       = result_q;
    assign opr1_o         = opr1_q;
    assign pe_out_o       = pe_out_q;
    assign pe_num_o       = pe_num_q;
    assign f_mem_w_o      = f_mem_w_q;
    assign next_lr_o      = next_lr_q;
    assign next_node_o    = next_node_q;
    assign gen_o          = gen_q;
    assign next_uni_opr_o = next_uni_opr_q;
    assign misalign_o     = misalign_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_mem1_stage.sv
// tb_mem1_stage: directed + randomized bench for mem1_stage against a
// byte-array behavioural model; outputs compared every cycle.
module tb_mem1_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] opr0_i;
    logic [31:0] opr1_i;
    logic [13:0] dm_addr_i;
    logic        mem_wen_i;
    logic [2:0]  dm_dopc_i;
    logic        pe_out_i;
    logic [2:0]  pe_num_i;
    logic        f_mem_w_i;
    logic        next_lr_i;
    logic [15:0] next_node_i;
    logic [11:0] gen_i;
    logic        next_uni_opr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [31:0] opr1_o;
    logic        pe_out_o;
    logic [2:0]  pe_num_o;
    logic        f_mem_w_o;
    logic        next_lr_o;
    logic [15:0] next_node_o;
    logic [11:0] gen_o;
    logic        next_uni_opr_o;
    logic        misalign_o;
    logic        err_o;

    int n_chk = 0;
    int n_err = 0;

    mem1_stage dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .opr0_i(opr0_i), .opr1_i(opr1_i),
        .dm_addr_i(dm_addr_i), .mem_wen_i(mem_wen_i), .dm_dopc_i(dm_dopc_i),
        .pe_out_i(pe_out_i), .pe_num_i(pe_num_i), .f_mem_w_i(f_mem_w_i),
        .next_lr_i(next_lr_i), .next_node_i(next_node_i), .gen_i(gen_i),
        .next_uni_opr_i(next_uni_opr_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .opr1_o(opr1_o),
        .pe_out_o(pe_out_o), .pe_num_o(pe_num_o), .f_mem_w_o(f_mem_w_o),
        .next_lr_o(next_lr_o), .next_node_o(next_node_o), .gen_o(gen_o),
        .next_uni_opr_o(next_uni_opr_o),
        .misalign_o(misalign_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0]  mm [16384];
    bit          m_init = 0;
    bit          m_acc  = 0;
    bit          m_valid;
    logic [31:0] m_result;
    logic [31:0] m_opr1;
    logic        m_pe_out;
    logic [2:0]  m_pe_num;
    logic        m_f_mem_w;
    logic        m_next_lr;
    logic [15:0] m_next_node;
    logic [11:0] m_gen;
    logic        m_next_uni;
    bit          m_mis;
    bit          m_err;

    function automatic void model_token();
        int sz = int'(dm_dopc_i[1:0]);
        int a  = int'(dm_addr_i);
        int n  = (sz == 1) ? 1 : (sz == 2) ? 2 : 4;
        bit bad = (sz == 2 && a % 2 != 0) || (sz == 3 && a % 4 != 0);
        logic [31:0] v = 0;
        m_mis = 0;
        if (sz == 0) begin
            m_result = opr0_i;
        end else if (bad) begin
            m_result = 0;
            m_mis = 1;
            m_err = 1;
        end else if (mem_wen_i) begin
            for (int k = 0; k < n; k++) mm[a+k] = opr1_i[8*k +: 8];
            m_result = opr0_i;
        end else begin
            for (int k = 0; k < n; k++) v = v | (32'(mm[a+k]) << (8*k));
            if (!dm_dopc_i[2] && n < 4 && v[8*n-1])
                v = v | (32'hFFFF_FFFF << (8*n));
            m_result = v;
        end
        m_opr1      = opr1_i;
        m_pe_out    = pe_out_i;
        m_pe_num    = pe_num_i;
        m_f_mem_w   = f_mem_w_i;
        m_next_lr   = next_lr_i;
        m_next_node = next_node_i;
        m_gen       = gen_i;
        m_next_uni  = next_uni_opr_i;
    endfunction

    always @(posedge clk) begin
        m_acc = 0;
        if (rst) begin
            m_init = 1;
            m_valid = 0; m_result = 0; m_opr1 = 0; m_pe_out = 0;
            m_pe_num = 0; m_f_mem_w = 0; m_next_lr = 0; m_next_node = 0;
            m_gen = 0; m_next_uni = 0; m_mis = 0; m_err = 0;
        end else if (valid_i && (!m_valid || ready_i)) begin
            m_acc = 1;
            model_token();
            m_valid = 1;
        end else if (ready_i) begin
            m_valid = 0;
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("valid_o", 32'(valid_o), 32'(m_valid));
            chk("ready_o", 32'(ready_o), 32'(!m_valid || ready_i));
            chk("err_o", 32'(err_o), 32'(m_err));
            chk("misalign_o", 32'(misalign_o), 32'(m_mis));
            chk("result_o", result_o, m_result);
            chk("opr1_o", opr1_o, m_opr1);
            chk("sideband", {pe_out_o, pe_num_o, f_mem_w_o, next_lr_o,
                             next_node_o, gen_o[7:0]},
                {m_pe_out, m_pe_num, m_f_mem_w, m_next_lr,
                 m_next_node, m_gen[7:0]});
            chk("gen_o", 32'(gen_o), 32'(m_gen));
            chk("next_uni_opr_o", 32'(next_uni_opr_o), 32'(m_next_uni));
        end
    end

    // ---------------- stimulus ----------------
    task automatic rand_sb();
        pe_out_i       = 1'($urandom_range(0, 1));
        pe_num_i       = 3'($urandom_range(0, 7));
        f_mem_w_i      = 1'($urandom_range(0, 1));
        next_lr_i      = 1'($urandom_range(0, 1));
        next_node_i    = 16'($urandom);
        gen_i          = 12'($urandom);
        next_uni_opr_i = 1'($urandom_range(0, 1));
    endtask

    task automatic drive(bit st, logic [2:0] dopc, logic [13:0] a,
                         logic [31:0] o0, logic [31:0] o1);
        mem_wen_i = st;
        dm_dopc_i = dopc;
        dm_addr_i = a;
        opr0_i    = o0;
        opr1_i    = o1;
        valid_i   = 1'b1;
    endtask

    task automatic wait_acc();
        int k;
        for (k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (m_acc) break;
        end
        if (k == 20) begin
            n_chk++; n_err++;
            $display("FAIL accept_timeout: got no accept expected accept");
        end
    endtask

    task automatic send(bit st, logic [2:0] dopc, logic [13:0] a,
                        logic [31:0] o0, logic [31:0] o1);
        drive(st, dopc, a, o0, o1);
        wait_acc();
    endtask

    task automatic send_chk(string nm, bit st, logic [2:0] dopc,
                            logic [13:0] a, logic [31:0] o0,
                            logic [31:0] o1, logic [31:0] exp);
        send(st, dopc, a, o0, o1);
        valid_i = 1'b0;
        @(negedge clk);
        chk({nm, "_dut"}, result_o, exp);
        chk({nm, "_model"}, m_result, exp);
        chk({nm, "_valid"}, 32'(valid_o), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        drive(0, 3'b000, 14'd0, 32'd0, 32'd0);
        valid_i = 1'b0;
        rand_sb();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_result", result_o, 32'd0);
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++)
            send(1, 3'b011, 14'(w * 4), 32'd0, 32'hA500_0000 | 32'(w * 4));

        // word store / load and sub-word access
        send_chk("st_word", 1, 3'b011, 14'h10, 32'h0BAD_F00D, 32'hDEAD_BEEF,
                 32'h0BAD_F00D);
        send_chk("ld_word", 0, 3'b011, 14'h10, 32'd0, 32'd0, 32'hDEAD_BEEF);
        send(1, 3'b001, 14'h13, 32'd1, 32'h0000_005A);
        send_chk("ld_after_byte", 0, 3'b011, 14'h10, 32'd0, 32'd0,
                 32'h5AAD_BEEF);
        send_chk("ld_sbyte", 0, 3'b001, 14'h13, 32'd0, 32'd0, 32'h0000_005A);
        send_chk("ld_shalf", 0, 3'b010, 14'h10, 32'd0, 32'd0, 32'hFFFF_BEEF);
        send_chk("ld_zhalf", 0, 3'b110, 14'h10, 32'd0, 32'd0, 32'h0000_BEEF);
        send_chk("ld_sbyte_neg", 0, 3'b001, 14'h10, 32'd0, 32'd0,
                 32'hFFFF_FFEF);

        // misaligned store leaves memory alone and sets sticky error
        send(1, 3'b011, 14'h11, 32'h1111_1111, 32'h7777_7777);
        valid_i = 1'b0;
        @(negedge clk);
        chk("mis_flag", 32'(misalign_o), 32'd1);
        chk("mis_result", result_o, 32'd0);
        chk("mis_err", 32'(err_o), 32'd1);
        @(posedge clk); #1;
        send_chk("after_mis", 0, 3'b011, 14'h10, 32'd0, 32'd0, 32'h5AAD_BEEF);
        @(negedge clk);
        chk("after_mis_flag", 32'(misalign_o), 32'd0);
        chk("err_sticky", 32'(err_o), 32'd1);
        @(posedge clk); #1;

        // passthrough with fixed sideband
        gen_i = 12'hABC; next_node_i = 16'h1234;
        send_chk("pass", 0, 3'b000, 14'h10, 32'h1234_5678, 32'h9, 32'h1234_5678);
        chk("pass_gen", 32'(gen_o), 32'h0000_0ABC);
        chk("pass_node", 32'(next_node_o), 32'h0000_1234);

        // backpressure: a held store waits for the stall to end
        idle();
        ready_i = 1'b0;
        send(0, 3'b011, 14'h10, 32'd0, 32'd0);
        drive(1, 3'b011, 14'h20, 32'd0, 32'h1122_3344);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", 32'(ready_o), 32'd0);
            chk("stall_hold", result_o, 32'h5AAD_BEEF);
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        wait_acc();
        send(0, 3'b011, 14'h20, 32'd0, 32'd0);
        send(0, 3'b011, 14'h10, 32'd0, 32'd0);
        send(0, 3'b011, 14'h00, 32'd0, 32'd0);
        send(0, 3'b011, 14'h04, 32'd0, 32'd0);
        send_chk("stream_raw", 0, 3'b011, 14'h20, 32'd0, 32'd0, 32'h1122_3344);

        // reset in the middle of a stall with a store pending
        ready_i = 1'b0;
        send(0, 3'b011, 14'h10, 32'd0, 32'd0);
        drive(1, 3'b011, 14'h24, 32'd0, 32'hCAFE_F00D);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_gen", 32'(gen_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        ready_i = 1'b1;
        send_chk("rst_no_write", 0, 3'b011, 14'h24, 32'd0, 32'd0,
                 32'hA500_0024);

        // randomized traffic over the preloaded window
        for (int c = 0; c < 600; c++) begin
            if (!valid_i || m_acc) begin
                valid_i   = ($urandom_range(0, 3) != 0);
                mem_wen_i = 1'($urandom_range(0, 1));
                dm_dopc_i = 3'($urandom_range(0, 7));
                dm_addr_i = 14'($urandom_range(0, 63));
                opr0_i    = $urandom;
                opr1_i    = $urandom;
                rand_sb();
            end
            ready_i = ($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
